serial_word_tx: RTL

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/comms_pkg.sv | 15 +
 rtl/baud_tick_gen.sv | 30 +++
 rtl/serial_word_tx.sv | 97 +++++++++
 3 files changed

// File: rtl/comms_pkg.sv
// Shared comms definitions: transmitter FSM encoding and default frame constants.
package comms_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE       = 8;
  localparam int unsigned DEFAULT_WORD_SIZE_WIDTH = 4;
  localparam int unsigned DEFAULT_CLKS_PER_BIT    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage : comms_pkg

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = enable && (cnt == LAST_CNT);

  // Clear has priority so a new frame always starts on a full bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule : baud_tick_gen

// File: rtl/serial_word_tx.sv
// Serial word transmitter: start bit, WORD_SIZE data bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles, with a valid/ready word input.
module serial_word_tx
  import comms_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = DEFAULT_WORD_SIZE,
  parameter int unsigned WORD_SIZE_WIDTH = DEFAULT_WORD_SIZE_WIDTH,
  parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [WORD_SIZE_WIDTH-1:0] LAST_BIT = WORD_SIZE_WIDTH'(WORD_SIZE - 1);

  tx_state_e                  state;
  logic [WORD_SIZE-1:0]       shift_reg;
  logic [WORD_SIZE_WIDTH-1:0] bit_cnt;
  logic                       baud_tick_c;
  logic                       accept_c;
  logic                       baud_clear_c;

  assign accept_c     = tx_valid && tx_ready;
  assign baud_clear_c = (state == IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (reset),
    .clear (baud_clear_c),
    .enable(tx_busy),
    .tick_c(baud_tick_c)
  );

  // Frame FSM; tx_serial is updated on the edge that starts each bit so it stays a pure flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            shift_reg <= tx_data;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (baud_tick_c) begin
            tx_serial <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (baud_tick_c) begin
            if (bit_cnt == LAST_BIT) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              tx_serial <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + WORD_SIZE_WIDTH'(1);
            end
          end
        end
        STOP: begin
          if (baud_tick_c) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_word_tx
